// File: rtl/mem_access_pkg.sv
// Shared definitions for the CPU-to-memory access controller:
// FSM state encoding and default parameter values.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mac_state_t;

  localparam int WORD_W_DEF         = 16;
  localparam int TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait counter for the access controller. Counts consecutive cycles with
// i_run high and flags the LIMIT-th such cycle; clears whenever i_run drops.
module mem_timeout_counter #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // count cycles spent waiting; restart from zero outside a wait
  always_ff @(posedge clk) begin
    if (reset || !i_run) r_cnt <= '0;
    else                 r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt is zero in the first waiting cycle, so LIMIT-1 marks the LIMIT-th
  assign o_expire = i_run && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-to-memory access controller. Turns level-held CPU read/write requests
// into a single memory access per request, with a one-cycle completion pulse.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to add an ack wait timeout
// and the sticky timeout_err output.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WORD_W         = WORD_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              readM,
  input  logic              writeM,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              inputReady,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  mac_state_t r_state;
  logic       r_consumed;
  logic       w_pending;
  logic       w_idle_req;

  // a held request is serviced once; it must drop before it counts again
  assign w_idle_req = !readM && !writeM;
  assign w_pending  = (readM || writeM) && !r_consumed;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic w_expire;

  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_run    (r_state == ST_ACCESS),
    .o_expire (w_expire)
  );
`else
  // parameter kept for interface compatibility; no wait limit in this build
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // access FSM: all CPU and memory side outputs are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_consumed  <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      inputReady  <= 1'b0;
      busy        <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      inputReady <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state   <= ST_ACCESS;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_addr  <= address;
            mem_wdata <= cpu_wdata;
            mem_we    <= writeM;  // write wins when both are requested
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            if (!mem_we) cpu_rdata <= mem_rdata;
            r_state    <= ST_DONE;
            mem_req    <= 1'b0;
            inputReady <= 1'b1;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (w_expire) begin
            cpu_rdata   <= '1;
            timeout_err <= 1'b1;
            r_state     <= ST_DONE;
            mem_req     <= 1'b0;
            inputReady  <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          busy       <= 1'b0;
          r_consumed <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
      // a dropped request re-arms acceptance, overriding the DONE set
      if (w_idle_req) r_consumed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues random CPU requests
// and plays the memory, pushing each expected completion into a queue; a
// monitor pops and checks on every inputReady pulse.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 15;
`endif

  logic        clk, reset, readM, writeM, mem_ack;
  logic [15:0] address, cpu_wdata, mem_rdata;
  logic [15:0] cpu_rdata, mem_addr, mem_wdata;
  logic        inputReady, busy, mem_req, mem_we;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        timeout_err;
`endif

  mem_access_ctrl #(.WORD_W(16), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .readM(readM), .writeM(writeM),
    .address(address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .inputReady(inputReady), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef MEM_ACCESS_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        expq[$];
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0;
  int          bursts = 0, exp_bursts = 0;
  logic [15:0] model_rdata = 16'h0;
  bit          mon_en = 0;
  logic        prev_req = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: completions against the scoreboard, plus per-cycle invariants
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", busy, mem_req || inputReady);
      if (mem_req && !prev_req) bursts++;
      prev_req = mem_req;
      if (inputReady) begin
        if (expq.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("ready_cycle", cyc, e.cyc);
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  // one CPU request plus the memory's side of it; w = wait cycles before ack
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rdat,
                        input int w, input int hold, input bit to);
    exp_t e;
    int n, g;
    @(negedge clk);
    readM = rd; writeM = wr; address = a; cpu_wdata = wd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
    e.we = wr; e.addr = a; e.wdata = wd;
    if (to) begin
      e.cyc = cyc + 1 + TO_CYC;
      model_rdata = 16'hFFFF;
    end else begin
      e.cyc = cyc + 2 + w;
      if (!wr) model_rdata = rdat;
    end
    e.rdata = model_rdata;
    expq.push_back(e);
    exp_bursts++;
    n = 0; g = 0;
    forever begin
      @(negedge clk);
      g++;
      address = 16'($urandom); cpu_wdata = 16'($urandom);
      if (mem_req) begin
        n++;
        mem_ack   = !to && (n == w + 1);
        mem_rdata = (n == w + 1) ? rdat : 16'($urandom);
      end else begin
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
        if (n > 0) break;
      end
      if (g > 60) begin
        chk("txn_bound", g, 0);
        break;
      end
    end
    repeat (hold) begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
    end
    @(negedge clk);
    readM = 0; writeM = 0;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; readM = 0; writeM = 0; address = 0; cpu_wdata = 0;
    mem_ack = 1; mem_rdata = 16'hFFFF;
    repeat (3) @(negedge clk);
    reset = 0; mem_ack = 0;
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_inputReady", inputReady, 0);
    chk("rst_busy", busy, 0);
`ifdef MEM_ACCESS_TIMEOUT_EN
    chk("rst_timeout_err", timeout_err, 0);
`endif
    mon_en = 1;

    do_txn(1, 0, 16'h0040, 16'h0000, 16'hBEEF, 2, 0, 0);  // 3-cycle read
    do_txn(0, 1, 16'h0010, 16'h1234, 16'h0000, 0, 0, 0);  // zero-wait write
    do_txn(1, 0, 16'h0020, 16'h0000, 16'h5A5A, 0, 3, 0);  // readM held 6 cycles
    do_txn(1, 1, 16'h0030, 16'h00AA, 16'h7777, 1, 0, 0);  // both -> write
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      do_txn(k != 1, k != 0, 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    // reset in the middle of a read: access abandoned, late ack ignored
    @(negedge clk);
    readM = 1; writeM = 0; address = 16'h0050; mem_ack = 0; exp_bursts++;
    @(negedge clk);
    mem_ack = 0;
    @(negedge clk);
    reset = 1; readM = 0;
    @(negedge clk);
    reset = 0;
    model_rdata = 16'h0;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    mem_ack = 1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 0;
    chk("rstmid_ready", inputReady, 0);
    chk("rstmid_cpu_rdata", cpu_rdata, 0);
    @(negedge clk);
    chk("rstmid_ready2", inputReady, 0);
    chk("rstmid_cpu_rdata2", cpu_rdata, 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    do_txn(1, 0, 16'h0060, 16'h0000, 16'h0000, 0, 0, 1);  // never acked
    chk("to_err_set", timeout_err, 1);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", timeout_err, 1);
    do_txn(1, 0, 16'h0070, 16'h0000, 16'h1111, 1, 0, 0);
    chk("to_err_after_ok", timeout_err, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_rdata = 16'h0;
    chk("to_err_clear", timeout_err, 0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    chk("burst_count", bursts, exp_bursts);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
